// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the processor memory-bus responder.
package mem_bus_pkg;

    localparam int WORD_W = 32;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_bus_responder_if.sv
// Processor memory bus: request strobe, address, data both ways, completion.
interface mem_bus_responder_if;
    import mem_bus_pkg::*;

    logic              enable;
    logic              op;
    logic [WORD_W-1:0] mar;
    logic [WORD_W-1:0] mbr_in;
    logic [WORD_W-1:0] mbr_out;
    logic              ready;
    logic              err;

    modport master (
        output enable, op, mar, mbr_in,
        input  mbr_out, ready, err
    );

    modport slave (
        input  enable, op, mar, mbr_in,
        output mbr_out, ready, err
    );

endinterface

// File: rtl/mem_bus_responder_sync_2ff.sv
// Two-flop synchronizer for asynchronous board input pins.
module sync_2ff #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two register stages give the first stage a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-bus responder: word RAM plus two memory-mapped I/O words, with
// programmable wait states and a one-cycle ready pulse per access.
// Optional feature macro: MEM_BUS_ERR_EN (error pulse for out-of-range
// accesses and writes to the input port; otherwise addresses wrap into RAM).
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2,
    parameter logic [31:0] IO_ADDR = 32'h0000_0400
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_bus_responder_if.slave  bus,
    input  logic [WORD_W-1:0]   pinos_input,
    output logic [WORD_W-1:0]   pinos_out
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] IN_ADDR = IO_ADDR + 32'd1;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              capture;
    logic              do_access;

    logic              req_op;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_data;

    logic [WORD_W-1:0] mbr_out_q;
    logic              ready_q;
    logic              err_q;
    logic [WORD_W-1:0] pinos_out_q;
    logic [WORD_W-1:0] pinos_sync;

    logic [WORD_W-1:0] ram [DEPTH];

    logic              is_out_port;
    logic              is_in_port;
    logic              is_ram;
    logic              err_flag;
    logic [IDX_W-1:0]  ram_idx;
    logic [WORD_W-1:0] rd_data;

    sync_2ff #(.WIDTH(WORD_W)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pinos_input),
        .q     (pinos_sync)
    );

    // FSM state and wait-state counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: the access edge is the one leaving RESP, so ready is high in the following cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        do_access = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    capture = 1'b1;
                    cnt_d   = 4'(LATENCY);
                    state_d = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                do_access = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address decode on the captured request address.
    always_comb begin
        is_out_port = (req_addr == IO_ADDR);
        is_in_port  = (req_addr == IN_ADDR);
`ifdef MEM_BUS_ERR_EN
        is_ram      = (req_addr < 32'(DEPTH));
        ram_idx     = req_addr[IDX_W-1:0];
        err_flag    = (!is_ram && !is_out_port && !is_in_port) ||
                      (is_in_port && (req_op == OP_WRITE));
`else
        is_ram      = !is_out_port && !is_in_port;
        ram_idx     = IDX_W'(req_addr % 32'(DEPTH));
        err_flag    = 1'b0;
`endif
    end

    // Read data mux; unmapped addresses read as zero.
    always_comb begin
        rd_data = '0;
        if (is_out_port) begin
            rd_data = pinos_out_q;
        end else if (is_in_port) begin
            rd_data = pinos_sync;
        end else if (is_ram) begin
            rd_data = ram[ram_idx];
        end
    end

    // Request capture, response registers and output port latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_op      <= OP_READ;
            req_addr    <= '0;
            req_data    <= '0;
            mbr_out_q   <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            pinos_out_q <= '0;
        end else begin
            if (capture) begin
                req_op   <= bus.op;
                req_addr <= bus.mar;
                req_data <= bus.mbr_in;
            end
            ready_q <= do_access;
            err_q   <= do_access && err_flag;
            if (do_access && (req_op == OP_READ)) begin
                mbr_out_q <= rd_data;
            end
            if (do_access && (req_op == OP_WRITE) && is_out_port) begin
                pinos_out_q <= req_data;
            end
        end
    end

    // RAM write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_access && (req_op == OP_WRITE) && is_ram) begin
            ram[ram_idx] <= req_data;
        end
    end

    assign bus.mbr_out = mbr_out_q;
    assign bus.ready   = ready_q;
    assign bus.err     = err_q;
    assign pinos_out   = pinos_out_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder (LATENCY=2 main instance plus a
// LATENCY=0 instance for back-to-back throughput).
module tb_mem_bus_responder;
    import mem_bus_pkg::*;

    localparam int          DEPTH   = 1024;
    localparam int          LAT     = 2;
    localparam logic [31:0] IO_ADDR = 32'h0000_0400;
    localparam logic [31:0] IN_ADDR = 32'h0000_0401;
`ifdef MEM_BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] expRd;
        logic        expErr;
        logic [31:0] expPout;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] pinos_input;
    logic [31:0] pinos_out;
    logic [31:0] pinos_input0;
    logic [31:0] pinos_out0;

    int checks = 0;
    int errors = 0;

    logic [31:0] modelRam [int];
    logic [31:0] modelPout;
    logic [31:0] modelLastRead;

    mem_bus_responder_if bus();
    mem_bus_responder_if bus0();

    mem_bus_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .IO_ADDR(IO_ADDR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .pinos_input (pinos_input),
        .pinos_out   (pinos_out)
    );

    mem_bus_responder #(.DEPTH(DEPTH), .LATENCY(0), .IO_ADDR(IO_ADDR)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus0),
        .pinos_input (pinos_input0),
        .pinos_out   (pinos_out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model of one access, straight from the address map rules.
    task automatic modelAccess(input logic op, input logic [31:0] addr, input logic [31:0] data,
                               output logic [31:0] expRd, output logic expErr);
        bit isOut, isIn, inRam, bad;
        int idx;
        isOut = (addr == IO_ADDR);
        isIn  = (addr == IN_ADDR);
        if (ERR_EN) begin
            inRam = (addr < DEPTH);
            bad   = !inRam && !isOut && !isIn;
            idx   = int'(addr);
        end else begin
            inRam = !isOut && !isIn;
            bad   = 1'b0;
            idx   = int'(addr % DEPTH);
        end
        expErr = ERR_EN && (bad || (isIn && op == OP_WRITE));
        if (op == OP_WRITE) begin
            if (isOut) modelPout = data;
            else if (inRam) modelRam[idx] = data;
        end else begin
            if (isOut) modelLastRead = modelPout;
            else if (isIn) modelLastRead = pinos_input;
            else if (inRam) modelLastRead = modelRam.exists(idx) ? modelRam[idx] : 32'h0;
            else modelLastRead = 32'h0;
        end
        expRd = modelLastRead;
    endtask

    // One bus transaction; returns the values seen in the ready cycle.
    task automatic busAccess(input logic op, input logic [31:0] addr, input logic [31:0] data,
                             output logic [31:0] rdata, output logic errv, output logic [31:0] pout,
                             output int lat, output logic pulseEnded);
        @(negedge clk);
        bus.enable = 1'b1;
        bus.op     = op;
        bus.mar    = addr;
        bus.mbr_in = data;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        bus.enable = 1'b0;
        while (!bus.ready && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus.ready) lat = -1;
        rdata = bus.mbr_out;
        errv  = bus.err;
        pout  = pinos_out;
        @(negedge clk);
        pulseEnded = !bus.ready;
    endtask

    task automatic applyStimulus(input string name, input logic op, input logic [31:0] addr,
                                 input logic [31:0] data, input bit useModel,
                                 input logic [31:0] tRd, input logic tErr, input logic [31:0] tPout);
        logic [31:0] mRd, rdata, pout;
        logic mErr, errv, pulseEnded;
        int lat;
        modelAccess(op, addr, data, mRd, mErr);
        busAccess(op, addr, data, rdata, errv, pout, lat, pulseEnded);
        checkOutput({name, " latency"}, 32'(lat), 32'(LAT + 1));
        checkOutput({name, " mbr_out"}, rdata, useModel ? mRd : tRd);
        checkOutput({name, " err"}, 32'(errv), 32'(useModel ? mErr : tErr));
        checkOutput({name, " pinos_out"}, pout, useModel ? modelPout : tPout);
        checkOutput({name, " ready width"}, 32'(pulseEnded), 32'd1);
    endtask

    vec_t vecs[14];

    initial begin
        int readyCount;
        logic [31:0] seenData;
        logic [31:0] addr;
        logic        op;

        bus.enable = 1'b0; bus.op = OP_READ; bus.mar = '0; bus.mbr_in = '0;
        bus0.enable = 1'b0; bus0.op = OP_READ; bus0.mar = '0; bus0.mbr_in = '0;
        pinos_input = 32'd10;
        pinos_input0 = 32'd0;
        modelPout = '0;
        modelLastRead = '0;

        vecs[0]  = '{OP_WRITE, 32'd5,       32'h0000_00AB, 32'h0,    1'b0,   32'h0};
        vecs[1]  = '{OP_READ,  32'd5,       32'h0,         32'hAB,   1'b0,   32'h0};
        vecs[2]  = '{OP_WRITE, IO_ADDR,     32'h0000_1234, 32'hAB,   1'b0,   32'h1234};
        vecs[3]  = '{OP_READ,  IO_ADDR,     32'h0,         32'h1234, 1'b0,   32'h1234};
        vecs[4]  = '{OP_READ,  IN_ADDR,     32'h0,         32'd10,   1'b0,   32'h1234};
        vecs[5]  = '{OP_WRITE, IN_ADDR,     32'hFFFF,      32'd10,   ERR_EN, 32'h1234};
        vecs[6]  = '{OP_READ,  IN_ADDR,     32'h0,         32'd10,   1'b0,   32'h1234};
        vecs[7]  = '{OP_WRITE, 32'd0,       32'hCAFE,      32'd10,   1'b0,   32'h1234};
        vecs[8]  = '{OP_READ,  32'h2000,    32'h0,         ERR_EN ? 32'h0 : 32'hCAFE, ERR_EN, 32'h1234};
        vecs[9]  = '{OP_WRITE, 32'd1023,    32'h3FF3,      ERR_EN ? 32'h0 : 32'hCAFE, 1'b0, 32'h1234};
        vecs[10] = '{OP_READ,  32'd1023,    32'h0,         32'h3FF3, 1'b0,   32'h1234};
        vecs[11] = '{OP_WRITE, 32'h2005,    32'h77,        32'h3FF3, ERR_EN, 32'h1234};
        vecs[12] = '{OP_READ,  32'd5,       32'h0,         ERR_EN ? 32'hAB : 32'h77, 1'b0, 32'h1234};
        vecs[13] = '{OP_READ,  IO_ADDR,     32'h0,         32'h1234, 1'b0,   32'h1234};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset ready", 32'(bus.ready), 32'd0);
        checkOutput("reset err", 32'(bus.err), 32'd0);
        checkOutput("reset mbr_out", bus.mbr_out, 32'd0);
        checkOutput("reset pinos_out", pinos_out, 32'd0);
        rst_n = 1'b1;
        readyCount = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.ready || bus.err) readyCount++;
        end
        checkOutput("idle no ready", 32'(readyCount), 32'd0);
        checkOutput("idle mbr_out", bus.mbr_out, 32'd0);
        checkOutput("idle pinos_out", pinos_out, 32'd0);

        // Directed table
        for (int i = 0; i < 14; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].data, 1'b0,
                          vecs[i].expRd, vecs[i].expErr, vecs[i].expPout);
        end

        // LATENCY=0 instance: a request every 2 cycles, enable held high
        for (int n = 0; n < 16; n++) begin
            bus0.enable = 1'b1;
            bus0.op     = (n < 8) ? OP_WRITE : OP_READ;
            bus0.mar    = 32'(n % 8);
            bus0.mbr_in = 32'((n % 8) * 3);
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("lat0 early ready %0d", n), 32'(bus0.ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("lat0 ready %0d", n), 32'(bus0.ready), 32'd1);
            if (n >= 8) checkOutput($sformatf("lat0 rdata %0d", n), bus0.mbr_out, 32'((n % 8) * 3));
        end
        bus0.enable = 1'b0;

        // Initialise the RAM words the random phase uses
        for (int i = 0; i < 20; i++) begin
            addr = (i < 16) ? 32'(i) : 32'(1020 + i - 16);
            applyStimulus("init", OP_WRITE, addr, $urandom, 1'b1, '0, 1'b0, '0);
        end

        // Randomized accesses against the model
        for (int i = 0; i < 50; i++) begin
            case ($urandom_range(0, 4))
                0: addr = 32'($urandom_range(0, 15));
                1: addr = 32'($urandom_range(1020, 1023));
                2: addr = IO_ADDR;
                3: addr = IN_ADDR;
                default: addr = ($urandom_range(0, 1) == 0) ? 32'(32'h3000 + $urandom_range(0, 15))
                                                             : 32'(IO_ADDR + 2 + $urandom_range(0, 13));
            endcase
            op = ($urandom_range(0, 1) == 1) ? OP_WRITE : OP_READ;
            pinos_input = $urandom;
            applyStimulus($sformatf("rand%0d", i), op, addr, $urandom, 1'b1, '0, 1'b0, '0);
        end

        // Busy: a second request during WAIT is ignored
        applyStimulus("busy prep10", OP_WRITE, 32'd10, 32'h55, 1'b1, '0, 1'b0, '0);
        applyStimulus("busy prep11", OP_WRITE, 32'd11, 32'h66, 1'b1, '0, 1'b0, '0);
        @(negedge clk);
        bus.enable = 1'b1; bus.op = OP_READ; bus.mar = 32'd10;
        @(posedge clk);
        @(negedge clk);
        bus.mar = 32'd11;
        @(posedge clk);
        @(negedge clk);
        bus.enable = 1'b0;
        readyCount = 0;
        seenData = '0;
        repeat (8) begin
            @(negedge clk);
            if (bus.ready) begin
                readyCount++;
                seenData = bus.mbr_out;
            end
        end
        checkOutput("busy ready count", 32'(readyCount), 32'd1);
        checkOutput("busy rdata", seenData, 32'h55);
        modelLastRead = 32'h55;

        // Abort: reset during WAIT of a write leaves RAM untouched
        applyStimulus("abort prep", OP_WRITE, 32'd9, 32'h99, 1'b1, '0, 1'b0, '0);
        @(negedge clk);
        bus.enable = 1'b1; bus.op = OP_WRITE; bus.mar = 32'd9; bus.mbr_in = 32'hDEAD;
        @(posedge clk);
        @(negedge clk);
        bus.enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        readyCount = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ready) readyCount++;
        end
        checkOutput("abort no ready", 32'(readyCount), 32'd0);
        checkOutput("abort mbr_out", bus.mbr_out, 32'd0);
        checkOutput("abort pinos_out", pinos_out, 32'd0);
        modelPout = '0;
        modelLastRead = '0;
        applyStimulus("abort readback", OP_READ, 32'd9, 32'h0, 1'b0, 32'h99, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
